// File: rtl/cve2_pkg.sv
// Shared types and bounds for the OBI instruction/data arbiter.
package cve2_pkg;

    typedef enum logic {
        SrcInstr = 1'b0,
        SrcData  = 1'b1
    } obi_src_e;

    localparam int unsigned MaxOutstandingBound = 4;

endpackage

// File: rtl/cve2_obi_arbiter_if.sv
// Shared OBI memory-port bundle; master is the arbiter side, slave the memory side.
interface cve2_obi_arbiter_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/cve2_obi_src_fifo.sv
// Outstanding-transaction FIFO holding the requester ID of each granted request.
module cve2_obi_src_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  obi_src_e push_src_i,
    input  logic     pop_i,
    output obi_src_e head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    obi_src_e        mem_q [Depth];
    obi_src_e        mem_d [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = push_src_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: SrcInstr};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cve2_obi_arbiter.sv
// Round-robin arbiter merging instruction fetch and load/store onto one OBI port,
// routing responses back in order via the outstanding-ID FIFO.
module cve2_obi_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        busy_o,
    output logic        spurious_rsp_o
);

    // Out-of-range depths are clamped rather than producing a malformed FIFO.
    localparam int unsigned Depth = (MaxOutstanding > MaxOutstandingBound) ? MaxOutstandingBound :
                                    (MaxOutstanding < 1) ? 1 : MaxOutstanding;

    obi_src_e winner;
    obi_src_e head;
    logic     fifo_full, fifo_empty;
    logic     push, rsp_ok;
    logic     data_sel;

    logic     lock_q, lock_d;
    obi_src_e lock_src_q, lock_src_d;
    obi_src_e prio_q, prio_d;
    logic     spurious_q, spurious_d;

    always_comb begin
        if (lock_q)                        winner = lock_src_q;
        else if (instr_req_i & data_req_i) winner = prio_q;
        else if (data_req_i)               winner = SrcData;
        else                               winner = SrcInstr;
    end

    assign bus_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
    assign data_sel    = bus_req_o & (winner == SrcData);
    assign bus_we_o    = data_sel & data_we_i;
    assign bus_be_o    = data_sel ? data_be_i : (bus_req_o ? 4'hF : 4'h0);
    assign bus_addr_o  = data_sel ? data_addr_i : (bus_req_o ? instr_addr_i : 32'h0);
    assign bus_wdata_o = data_sel ? data_wdata_i : 32'h0;

    assign push        = bus_req_o & bus_gnt_i;
    assign instr_gnt_o = push & (winner == SrcInstr);
    assign data_gnt_o  = push & (winner == SrcData);

    assign rsp_ok         = bus_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = rsp_ok & (head == SrcInstr);
    assign data_rvalid_o  = rsp_ok & (head == SrcData);
    assign rsp_rdata_o    = bus_rdata_i;
    assign rsp_err_o      = bus_err_i;

    assign busy_o         = ~fifo_empty | instr_req_i | data_req_i;
    assign spurious_rsp_o = spurious_q;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        prio_d     = prio_q;
        spurious_d = spurious_q | (bus_rvalid_i & fifo_empty);
        if (bus_req_o & ~bus_gnt_i) begin
            lock_d     = 1'b1;
            lock_src_d = winner;
        end else if (push) begin
            lock_d = 1'b0;
            prio_d = (winner == SrcData) ? SrcInstr : SrcData;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= SrcData;
            prio_q     <= SrcData;
            spurious_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            prio_q     <= prio_d;
            spurious_q <= spurious_d;
        end
    end

    cve2_obi_src_fifo #(
        .Depth(Depth)
    ) u_src_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .push_src_i (winner),
        .pop_i      (bus_rvalid_i),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Directed bench for cve2_obi_arbiter: arbitration order, locking, FIFO limits, response routing.
module tb_cve2_obi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o, spurious_rsp_o;

    int n_chk  = 0;
    int n_fail = 0;

    cve2_obi_arbiter_if bus_if ();

    always #5 clk_i = ~clk_i;

    cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .bus_req_o      (bus_if.req),
        .bus_gnt_i      (bus_if.gnt),
        .bus_we_o       (bus_if.we),
        .bus_be_o       (bus_if.be),
        .bus_addr_o     (bus_if.addr),
        .bus_wdata_o    (bus_if.wdata),
        .bus_rvalid_i   (bus_if.rvalid),
        .bus_rdata_i    (bus_if.rdata),
        .bus_err_i      (bus_if.err),
        .busy_o         (busy_o),
        .spurious_rsp_o (spurious_rsp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        instr_req_i   = ir;
        data_req_i    = dr;
        bus_if.gnt    = gnt;
        bus_if.rvalid = rv;
        bus_if.rdata  = rd;
        #2;
    endtask

    // Alternation pattern: expected {data_gnt, instr_gnt, data_rvalid, instr_rvalid} per cycle.
    logic [3:0] alt_exp [5] = '{4'b1000, 4'b0110, 4'b1001, 4'b0110, 4'b0001};

    initial begin
        rst_ni        = 1'b0;
        instr_req_i   = 1'b0;
        instr_addr_i  = 32'h0000_1000;
        data_req_i    = 1'b0;
        data_we_i     = 1'b1;
        data_be_i     = 4'h3;
        data_addr_i   = 32'h0000_2000;
        data_wdata_i  = 32'hDEAD_BEEF;
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = 32'h0;
        bus_if.err    = 1'b0;
        step();
        step();
        #2;
        chk("rst_bus_req", bus_if.req, 0);
        chk("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
        chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_spurious", spurious_rsp_o, 0);
        chk("rst_be", bus_if.be, 0);
        rst_ni = 1'b1;
        step();

        // Both requesting, grant every cycle: D,I,D,I then drain.
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, i < 4, 1'b1, i > 0, 32'h0);
            chk($sformatf("alt_c%0d", i),
                {data_gnt_o, instr_gnt_o, data_rvalid_o, instr_rvalid_o}, alt_exp[i]);
            if (i == 0) begin
                chk("alt_d_addr", bus_if.addr, 32'h0000_2000);
                chk("alt_d_be", bus_if.be, 4'h3);
                chk("alt_d_wdata", bus_if.wdata, 32'hDEAD_BEEF);
                chk("alt_d_we", bus_if.we, 1);
            end
            if (i == 1) begin
                chk("alt_i_addr", bus_if.addr, 32'h0000_1000);
                chk("alt_i_be", bus_if.be, 4'hF);
                chk("alt_i_wdata", bus_if.wdata, 0);
                chk("alt_i_we", bus_if.we, 0);
            end
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("alt_idle_busy", busy_o, 0);

        // One data transaction so instr holds priority going into the lock test.
        drive(0, 1, 1, 0, 0);
        chk("pre_d_gnt", data_gnt_o, 1);
        step();
        drive(0, 0, 0, 1, 0);
        chk("pre_d_rvalid", data_rvalid_o, 1);
        step();

        // Lock: data waits 3 cycles at 0x100, instr rises in cycle 2.
        data_addr_i = 32'h0000_0100;
        data_we_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i > 0, 1, 0, 0, 0);
            chk($sformatf("lock_addr_c%0d", i), bus_if.addr, 32'h0000_0100);
            chk($sformatf("lock_gnts_c%0d", i), {instr_gnt_o, data_gnt_o}, 0);
            chk($sformatf("lock_req_c%0d", i), bus_if.req, 1);
            step();
        end
        drive(1, 1, 1, 0, 0);
        chk("lock_grant_addr", bus_if.addr, 32'h0000_0100);
        chk("lock_grant_gnts", {instr_gnt_o, data_gnt_o}, 2'b01);
        step();
        drive(1, 0, 1, 0, 0);
        chk("lock_next_instr", {instr_gnt_o, data_gnt_o}, 2'b10);
        chk("lock_next_addr", bus_if.addr, 32'h0000_1000);
        step();

        // FIFO full (D,I): requests blocked, still blocked in the pop cycle.
        drive(1, 1, 1, 0, 0);
        chk("full_req", bus_if.req, 0);
        chk("full_gnts", {instr_gnt_o, data_gnt_o}, 0);
        step();
        bus_if.err = 1'b1;
        drive(1, 1, 1, 1, 32'h1111);
        chk("full_pop_req", bus_if.req, 0);
        chk("full_pop_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b01);
        chk("full_pop_rdata", rsp_rdata_o, 32'h1111);
        chk("full_pop_err", rsp_err_o, 1);
        step();
        bus_if.err = 1'b0;
        drive(1, 1, 0, 0, 0);
        chk("reassert_req", bus_if.req, 1);
        chk("reassert_gnts", {instr_gnt_o, data_gnt_o}, 0);
        step();
        drive(1, 1, 1, 0, 0);
        chk("reassert_d_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
        step();

        // In-order routing: I answered with 0xAAAA, then D with 0x5555.
        drive(0, 0, 0, 1, 32'hAAAA);
        chk("rsp1_valid", {instr_rvalid_o, data_rvalid_o}, 2'b10);
        chk("rsp1_rdata", rsp_rdata_o, 32'hAAAA);
        step();
        drive(0, 0, 0, 1, 32'h5555);
        chk("rsp2_valid", {instr_rvalid_o, data_rvalid_o}, 2'b01);
        chk("rsp2_rdata", rsp_rdata_o, 32'h5555);
        step();

        // Response with nothing outstanding.
        drive(0, 0, 0, 1, 32'h7);
        chk("spur_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("spur_flag", spurious_rsp_o, 1);
        chk("spur_busy", busy_o, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("spur_sticky", spurious_rsp_o, 1);
        step();

        // Reset with one transaction outstanding.
        drive(1, 0, 1, 0, 0);
        chk("rst_mid_gnt", instr_gnt_o, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("rst_mid_busy_pre", busy_o, 1);
        rst_ni = 1'b0;
        step();
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_spur", spurious_rsp_o, 0);
        rst_ni = 1'b1;
        step();
        drive(0, 0, 0, 1, 32'h9);
        chk("post_rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("post_rst_spur", spurious_rsp_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
